// File: rtl/lab3_4_serial_sub.sv
// Bit-serial subtractor for the board top level: computes SW[7:4] - SW[3:0] - SW[9]
// one bit per step, LSB first, and shows difference, borrow-out and status on LEDR.
module lab3_4_serial_sub #(
  parameter int WIDTH    = 4,
  parameter int STEP_DIV = 1
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic clk;
  logic rst_n;
  assign clk   = CLOCK_50;
  assign rst_n = KEY[0];

  logic unused_inputs;
  assign unused_inputs = ^{KEY[3:2], SW[8]};

  state_t           state;
  logic             k1_s1, k1_s2, k1_prev;
  logic             start_p;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             brw;
  logic [CW-1:0]    bit_cnt;
  logic [SW_W-1:0]  step_cnt;
  logic             tick;
  logic             d, brw_nxt;
  logic [WIDTH-1:0] led_res;
  logic             led_brw, busy, done;

  // NOTE: the synchronizer resets to 1, the released-button level, so coming out
  // of reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k1_s1   <= 1'b1;
      k1_s2   <= 1'b1;
      k1_prev <= 1'b1;
    end else begin
      k1_s1   <= KEY[1];
      k1_s2   <= k1_s1;
      k1_prev <= k1_s2;
    end
  end

  assign start_p = k1_prev & ~k1_s2;
  assign tick    = (step_cnt == SW_W'(STEP_DIV - 1));
  assign d       = a_sh[0] ^ b_sh[0] ^ brw;
  assign brw_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);

  // NOTE: every register here uses non-blocking assignments so all of them see the
  // pre-edge values of a_sh, b_sh, brw and res within the same step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      brw      <= 1'b0;
      bit_cnt  <= '0;
      step_cnt <= '0;
      led_res  <= '0;
      led_brw  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_p) begin
            a_sh     <= SW[7:4];
            b_sh     <= SW[3:0];
            brw      <= SW[9];
            res      <= '0;
            bit_cnt  <= '0;
            step_cnt <= '0;
            led_res  <= '0;
            led_brw  <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            a_sh     <= a_sh >> 1;
            b_sh     <= b_sh >> 1;
            brw      <= brw_nxt;
            res      <= {d, res[WIDTH-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            step_cnt <= '0;
            // Result LEDs load only on the final step, so nothing partial is shown.
            if (bit_cnt == CW'(WIDTH - 1)) begin
              led_res <= {d, res[WIDTH-1:1]};
              led_brw <= brw_nxt;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign LEDR = {done, busy, 3'b000, led_brw, led_res};

endmodule

// File: tb/tb_lab3_4_serial_sub.sv
// Directed bench for lab3_4_serial_sub: one instance at STEP_DIV=1 for arithmetic and
// control checks, one at STEP_DIV=3 for step timing; both share the switch/key inputs.
module tb_lab3_4_serial_sub;

  logic       clk = 1'b0;
  logic [3:0] key;
  logic [9:0] sw;
  logic [9:0] ledr1, ledr3;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  lab3_4_serial_sub #(.WIDTH(4), .STEP_DIV(1)) dut1 (
    .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDR(ledr1)
  );

  lab3_4_serial_sub #(.WIDTH(4), .STEP_DIV(3)) dut3 (
    .CLOCK_50(clk), .KEY(key), .SW(sw), .LEDR(ledr3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int a, input int b, input int bin);
    sw = {1'(bin), 1'b0, 4'(a), 4'(b)};
  endtask

  task automatic press(input int hold);
    key[1] = 1'b0;
    repeat (hold) @(negedge clk);
    key[1] = 1'b1;
  endtask

  task automatic wait_busy1();
    int n;
    n = 0;
    while (!ledr1[8] && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Press start on the STEP_DIV=1 instance and check busy length, hidden result, final LEDR.
  task automatic run1(input string tag, input logic [9:0] exp);
    int  busy_n;
    bit  leak;
    press(2);
    wait_busy1();
    check({tag, " busy_rise"}, 32'(ledr1[8]), 32'd1);
    busy_n = 0;
    leak   = 1'b0;
    while (ledr1[8] && busy_n < 40) begin
      if (ledr1[4:0] != 5'd0) leak = 1'b1;
      @(negedge clk);
      busy_n++;
    end
    check({tag, " busy_cycles"}, 32'(busy_n), 32'd4);
    check({tag, " hidden_during_run"}, 32'(leak), 32'd0);
    check({tag, " ledr"}, 32'(ledr1), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int rises;
    logic prev;

    key = 4'b1111;
    sw  = '0;
    #2 key[0] = 1'b0;
    #1;
    check("reset ledr1", 32'(ledr1), 32'd0);
    check("reset ledr3", 32'(ledr3), 32'd0);
    repeat (2) @(negedge clk);
    key[0] = 1'b1;
    @(negedge clk);
    check("idle ledr1", 32'(ledr1), 32'd0);

    set_ops(9, 3, 0);  run1("9-3",    10'h206);
    set_ops(3, 9, 0);  run1("3-9",    10'h21A);
    set_ops(5, 5, 1);  run1("5-5-1",  10'h21F);
    set_ops(0, 0, 0);  run1("0-0",    10'h200);

    // Second press and switch changes during RUN must not disturb the operation.
    set_ops(9, 3, 0);
    press(2);
    wait_busy1();
    key[1] = 1'b0;
    set_ops(15, 0, 0);
    @(negedge clk);
    key[1] = 1'b1;
    rises = 0;
    prev  = ledr1[9];
    repeat (15) begin
      @(negedge clk);
      if (ledr1[9] && !prev) rises++;
      prev = ledr1[9];
    end
    check("ignore done_count", 32'(rises), 32'd1);
    check("ignore ledr", 32'(ledr1), 32'h206);
    run1("from_done 15-0", 10'h20F);

    // Asynchronous reset two steps into 9-3.
    repeat (20) @(negedge clk);
    set_ops(9, 3, 0);
    press(2);
    wait_busy1();
    repeat (2) @(negedge clk);
    #2 key[0] = 1'b0;
    #1;
    check("midrun reset ledr1", 32'(ledr1), 32'd0);
    check("midrun reset ledr3", 32'(ledr3), 32'd0);
    repeat (2) @(negedge clk);
    key[0] = 1'b1;
    @(negedge clk);
    check("post reset idle", 32'(ledr1), 32'd0);
    run1("after_reset 9-3", 10'h206);

    // STEP_DIV=3 timing with a long button hold.
    set_ops(7, 2, 1);
    repeat (30) @(negedge clk);
    fork
      press(20);
      begin
        int n;
        int busy_n;
        int extra;
        n = 0;
        while (!ledr3[8] && n < 10) begin
          @(negedge clk);
          n++;
        end
        check("div3 busy_rise", 32'(ledr3[8]), 32'd1);
        busy_n = 0;
        while (ledr3[8] && busy_n < 60) begin
          @(negedge clk);
          busy_n++;
        end
        check("div3 busy_cycles", 32'(busy_n), 32'd12);
        check("div3 ledr", 32'(ledr3), 32'h204);
        extra = 0;
        repeat (30) begin
          @(negedge clk);
          if (ledr3[8]) extra++;
        end
        check("div3 single_op", 32'(extra), 32'd0);
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
